// File: rtl/wb_serial_master_if.sv
// Bundle of the UART byte streams, Wishbone initiator signals and busy flag for wb_serial_master.
// master = the bridge itself; slave = the environment (UART, interconnect) facing it.
interface wb_serial_master_if;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        o_rx_ready;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic [31:0] o_wb_adr;
    logic [31:0] o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic [31:0] i_wb_dat;
    logic        i_wb_ack;
    logic        i_wb_err;
    logic        o_busy;

    modport master (
        input  i_rx_data, i_rx_valid, i_tx_ready, i_wb_dat, i_wb_ack, i_wb_err,
        output o_rx_ready, o_tx_data, o_tx_valid, o_wb_adr, o_wb_dat, o_wb_sel,
               o_wb_we, o_wb_cyc, o_wb_stb, o_busy
    );

    modport slave (
        output i_rx_data, i_rx_valid, i_tx_ready, i_wb_dat, i_wb_ack, i_wb_err,
        input  o_rx_ready, o_tx_data, o_tx_valid, o_wb_adr, o_wb_dat, o_wb_sel,
               o_wb_we, o_wb_cyc, o_wb_stb, o_busy
    );
endinterface

// File: rtl/wb_serial_master.sv
// UART byte-command to Wishbone initiator: 'W' addr[4] data[4] / 'R' addr[4], answers K/E(/T).
// Optional bus timeout enabled by defining WB_SERIAL_MASTER_TIMEOUT_EN.
module wb_serial_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               i_clk,
    input  logic               i_reset,
    wb_serial_master_if.master bus
);
    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] RSP_K = 8'h4B;
    localparam logic [7:0] RSP_E = 8'h45;
    localparam logic [7:0] RSP_T = 8'h54;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_e;

    state_e      state_q, state_d;
    logic        wr_q, wr_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [7:0]  status_q, status_d;
    logic [2:0]  txi_q, txi_d;

    logic       rx_fire, tx_fire, bus_timeout;
    logic [2:0] last_idx;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_cfg
        $error("wb_serial_master: TIMEOUT_CYCLES must be nonzero");
    end

    assign bus.o_rx_ready = ~i_reset & ((state_q == S_IDLE) | (state_q == S_ADDR) | (state_q == S_DATA));
    assign bus.o_tx_valid = (state_q == S_RESP);
    assign bus.o_tx_data  = (state_q != S_RESP) ? 8'h00 : (txi_q == 3'd0) ? status_q : dat_q[31:24];
    assign bus.o_wb_cyc   = (state_q == S_BUS);
    assign bus.o_wb_stb   = (state_q == S_BUS);
    assign bus.o_wb_we    = (state_q == S_BUS) & wr_q;
    assign bus.o_wb_adr   = {adr_q[31:2], 2'b00};
    assign bus.o_wb_dat   = dat_q;
    assign bus.o_wb_sel   = 4'hF;
    assign bus.o_busy     = (state_q != S_IDLE);

    assign rx_fire  = bus.i_rx_valid & bus.o_rx_ready;
    assign tx_fire  = bus.o_tx_valid & bus.i_tx_ready;
    // Only a successful read carries the four data bytes after the status byte.
    assign last_idx = (status_q == RSP_K && !wr_q) ? 3'd4 : 3'd0;

`ifdef WB_SERIAL_MASTER_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;

    assign tmo_d       = (state_q == S_BUS) ? tmo_q + 32'd1 : 32'd0;
    assign bus_timeout = (state_q == S_BUS) && (tmo_d == TIMEOUT_CYCLES);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) tmo_q <= 32'd0;
        else         tmo_q <= tmo_d;
    end
`else
    assign bus_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            wr_q     <= 1'b0;
            cnt_q    <= 2'd0;
            adr_q    <= 32'd0;
            dat_q    <= 32'd0;
            status_q <= 8'h00;
            txi_q    <= 3'd0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            cnt_q    <= cnt_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            status_q <= status_d;
            txi_q    <= txi_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        cnt_d    = cnt_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        status_d = status_q;
        txi_d    = txi_q;
        case (state_q)
            S_IDLE: begin
                if (rx_fire && (bus.i_rx_data == CMD_W || bus.i_rx_data == CMD_R)) begin
                    wr_d    = (bus.i_rx_data == CMD_W);
                    cnt_d   = 2'd0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (rx_fire) begin
                    adr_d = {adr_q[23:0], bus.i_rx_data};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = wr_q ? S_DATA : S_BUS;
                end
            end
            S_DATA: begin
                if (rx_fire) begin
                    dat_d = {dat_q[23:0], bus.i_rx_data};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = S_BUS;
                end
            end
            S_BUS: begin
                txi_d = 3'd0;
                // err beats ack; a real bus response beats a coincident timeout.
                if (bus.i_wb_err) begin
                    status_d = RSP_E;
                    state_d  = S_RESP;
                end else if (bus.i_wb_ack) begin
                    status_d = RSP_K;
                    if (!wr_q) dat_d = bus.i_wb_dat;
                    state_d  = S_RESP;
                end else if (bus_timeout) begin
                    status_d = RSP_T;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                if (tx_fire) begin
                    if (txi_q == last_idx) begin
                        state_d = S_IDLE;
                    end else begin
                        txi_d = txi_q + 3'd1;
                        if (txi_q != 3'd0) dat_d = {dat_q[23:0], 8'h00};
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_wb_serial_master.sv
// Bench for wb_serial_master: table vectors, hand sequences (reset mid-bus, timeout) and random
// commands checked against a byte-stream reference model.
module tb_wb_serial_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_serial_master_if ifc();

    wb_serial_master #(.TIMEOUT_CYCLES(16)) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (ifc.master)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- Wishbone slave model and bus-cycle recorder ----------------
    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          ncyc;
        bit          unstable;
    } op_t;

    bit          s_err = 0, s_ack_too = 0, s_noack = 0;
    int          s_delay = 0;
    logic [31:0] s_rdata = 32'h0;
    op_t         op_q[$];
    op_t         cur;
    bit          in_cyc = 0;

    always @(negedge clk) begin
        ifc.i_wb_ack = 1'b0;
        ifc.i_wb_err = 1'b0;
        ifc.i_wb_dat = 32'hBAD0_BAD0;
        if (ifc.o_wb_cyc) begin
            if (!in_cyc) begin
                cur.we = ifc.o_wb_we; cur.adr = ifc.o_wb_adr; cur.dat = ifc.o_wb_dat;
                cur.sel = ifc.o_wb_sel; cur.ncyc = 0; cur.unstable = 0; in_cyc = 1;
            end else if (ifc.o_wb_we !== cur.we || ifc.o_wb_adr !== cur.adr ||
                         ifc.o_wb_dat !== cur.dat || ifc.o_wb_stb !== 1'b1) begin
                cur.unstable = 1;
            end
            cur.ncyc++;
            if (!s_noack && cur.ncyc - 1 == s_delay) begin
                ifc.i_wb_ack = s_err ? s_ack_too : 1'b1;
                ifc.i_wb_err = s_err;
                ifc.i_wb_dat = s_rdata;
            end
        end else if (in_cyc) begin
            op_q.push_back(cur);
            in_cyc = 0;
        end
    end

    // ---------------- UART transmit sink with backpressure ----------------
    logic [7:0] tx_q[$];
    int         bp_cycles = 0;
    int         bp_cnt = 0;
    bit         pend = 0;
    logic [7:0] held;

    always @(negedge clk) begin
        if (rst || !ifc.o_tx_valid) begin
            ifc.i_tx_ready = 1'b0;
            pend = 0;
            bp_cnt = 0;
        end else begin
            if (pend) check("tx_hold", {24'h0, ifc.o_tx_data}, {24'h0, held});
            if (bp_cnt < bp_cycles) begin
                ifc.i_tx_ready = 1'b0;
                bp_cnt++;
                pend = 1;
                held = ifc.o_tx_data;
            end else begin
                ifc.i_tx_ready = 1'b1;
                tx_q.push_back(ifc.o_tx_data);
                bp_cnt = 0;
                pend = 0;
            end
        end
    end

    // ---------------- expectations ----------------
    logic [7:0]  m_tx[$];
    logic        m_we;
    logic [31:0] m_adr, m_dat;
    int          m_ncyc;
    logic [7:0]  cmd_q[$];

    // Reference: find the first command byte in the stream and derive bus op and reply.
    function automatic void model(input logic [7:0] s[$]);
        int i = 0;
        m_tx.delete();
        while (i < s.size() && s[i] != 8'h57 && s[i] != 8'h52) i++;
        m_we  = (s[i] == 8'h57);
        m_adr = {s[i+1], s[i+2], s[i+3], s[i+4]} & 32'hFFFF_FFFC;
        m_dat = m_we ? {s[i+5], s[i+6], s[i+7], s[i+8]} : 32'h0;
        if (s_noack) begin
            m_ncyc = 16;
            m_tx.push_back(8'h54);
        end else begin
            m_ncyc = s_delay + 1;
            if (s_err) m_tx.push_back(8'h45);
            else begin
                m_tx.push_back(8'h4B);
                if (!m_we) for (int k = 3; k >= 0; k--) m_tx.push_back(s_rdata[8*k +: 8]);
            end
        end
    endfunction

    function automatic void build(input int garb, input bit wr, input logic [31:0] adr,
                                  input logic [31:0] wdat, input bit rnd_garb);
        logic [7:0] g;
        cmd_q.delete();
        for (int k = 0; k < garb; k++) begin
            if (rnd_garb) begin
                g = 8'($urandom);
                if (g == 8'h57 || g == 8'h52) g = 8'h00;
            end else g = (k % 2 == 0) ? 8'h00 : 8'hFF;
            cmd_q.push_back(g);
        end
        cmd_q.push_back(wr ? 8'h57 : 8'h52);
        for (int k = 3; k >= 0; k--) cmd_q.push_back(adr[8*k +: 8]);
        if (wr) for (int k = 3; k >= 0; k--) cmd_q.push_back(wdat[8*k +: 8]);
    endfunction

    // Called at posedge+1 time unit; returns at posedge+1 after the byte transferred.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        ifc.i_rx_valid = 1'b1;
        ifc.i_rx_data  = b;
        while (!ifc.o_rx_ready && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 2000) check("rx_accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        ifc.i_rx_valid = 1'b0;
    endtask

    task automatic run_cmd(input string tag);
        int n = 0;
        op_q.delete();
        tx_q.delete();
        foreach (cmd_q[k]) send_byte(cmd_q[k]);
        check({tag, "_cyc_latency"}, {31'h0, ifc.o_wb_cyc}, 32'd1);
        check({tag, "_busy"}, {31'h0, ifc.o_busy}, 32'd1);
        while (tx_q.size() < m_tx.size() && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 3000) check({tag, "_resp_timeout"}, tx_q.size(), m_tx.size());
        check({tag, "_idle_after"}, {30'h0, ifc.o_busy, ifc.o_rx_ready}, 32'd1);
        @(posedge clk); #1;
        check({tag, "_ntx"}, tx_q.size(), m_tx.size());
        for (int k = 0; k < m_tx.size() && k < tx_q.size(); k++)
            check($sformatf("%s_tx%0d", tag, k), {24'h0, tx_q[k]}, {24'h0, m_tx[k]});
        check({tag, "_nops"}, op_q.size(), 32'd1);
        if (op_q.size() > 0) begin
            check({tag, "_we"}, {31'h0, op_q[0].we}, {31'h0, m_we});
            check({tag, "_adr"}, op_q[0].adr, m_adr);
            if (m_we) check({tag, "_dat"}, op_q[0].dat, m_dat);
            check({tag, "_sel"}, {28'h0, op_q[0].sel}, 32'hF);
            check({tag, "_ncyc"}, op_q[0].ncyc, m_ncyc);
            check({tag, "_stable"}, {31'h0, op_q[0].unstable}, 32'd0);
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        int          garb;
        bit          wr;
        logic [31:0] adr, wdat, rdat;
        bit          err, ack_too;
        int          delay, bp;
        logic [7:0]  exp_st;
        int          exp_ntx;
        logic [31:0] exp_adr;
    } vec_t;

    vec_t vt[7];

    initial begin
        vt[0] = '{0, 1'b1, 32'h2000_0100, 32'hDEAD_BEEF, 32'h0,         1'b0, 1'b0, 2, 0,  8'h4B, 1, 32'h2000_0100};
        vt[1] = '{0, 1'b0, 32'h2000_0100, 32'h0,         32'h1234_5678, 1'b0, 1'b0, 0, 0,  8'h4B, 5, 32'h2000_0100};
        vt[2] = '{0, 1'b0, 32'h4000_0000, 32'h0,         32'h0,         1'b1, 1'b0, 0, 0,  8'h45, 1, 32'h4000_0000};
        vt[3] = '{2, 1'b0, 32'h2000_0004, 32'h0,         32'hA5C3_0F96, 1'b0, 1'b0, 1, 10, 8'h4B, 5, 32'h2000_0004};
        vt[4] = '{0, 1'b1, 32'h1000_000B, 32'hCAFE_F00D, 32'h0,         1'b0, 1'b0, 0, 0,  8'h4B, 1, 32'h1000_0008};
        vt[5] = '{0, 1'b0, 32'h3000_0000, 32'h0,         32'h1122_3344, 1'b1, 1'b1, 3, 2,  8'h45, 1, 32'h3000_0000};
        vt[6] = '{0, 1'b1, 32'h0,         32'h0,         32'h0,         1'b1, 1'b0, 5, 1,  8'h45, 1, 32'h0};

        ifc.i_rx_valid = 1'b0;
        ifc.i_rx_data  = 8'h00;
        #12;
        check("rst_rx_ready", {31'h0, ifc.o_rx_ready}, 32'd0);
        check("rst_tx_valid", {31'h0, ifc.o_tx_valid}, 32'd0);
        check("rst_tx_data",  {24'h0, ifc.o_tx_data}, 32'd0);
        check("rst_cyc_stb_we", {29'h0, ifc.o_wb_cyc, ifc.o_wb_stb, ifc.o_wb_we}, 32'd0);
        check("rst_adr", ifc.o_wb_adr, 32'd0);
        check("rst_dat", ifc.o_wb_dat, 32'd0);
        check("rst_sel", {28'h0, ifc.o_wb_sel}, 32'hF);
        check("rst_busy", {31'h0, ifc.o_busy}, 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("idle_rx_ready", {31'h0, ifc.o_rx_ready}, 32'd1);

        for (int v = 0; v < 7; v++) begin
            s_err = vt[v].err; s_ack_too = vt[v].ack_too; s_noack = 0;
            s_delay = vt[v].delay; s_rdata = vt[v].rdat; bp_cycles = vt[v].bp;
            build(vt[v].garb, vt[v].wr, vt[v].adr, vt[v].wdat, 1'b0);
            m_tx.delete();
            m_tx.push_back(vt[v].exp_st);
            if (vt[v].exp_ntx == 5) for (int k = 3; k >= 0; k--) m_tx.push_back(vt[v].rdat[8*k +: 8]);
            m_we = vt[v].wr; m_adr = vt[v].exp_adr; m_dat = vt[v].wdat; m_ncyc = vt[v].delay + 1;
            run_cmd($sformatf("vec%0d", v));
        end

        // Reset while the bus cycle is pending: outputs drop without a clock edge.
        s_noack = 1; s_err = 0; bp_cycles = 0;
        build(0, 1'b0, 32'h2000_0040, 32'h0, 1'b0);
        foreach (cmd_q[k]) send_byte(cmd_q[k]);
        repeat (3) @(posedge clk);
        #2;
        check("mid_cyc_before_rst", {31'h0, ifc.o_wb_cyc}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_async_cyc_stb", {30'h0, ifc.o_wb_cyc, ifc.o_wb_stb}, 32'd0);
        check("rst_async_busy_txv", {30'h0, ifc.o_busy, ifc.o_tx_valid}, 32'd0);
        @(negedge clk) rst = 1'b0;
        s_noack = 0; s_delay = 1;
        @(posedge clk); #1;
        build(0, 1'b1, 32'h2000_0200, 32'h0BAD_CAFE, 1'b0);
        model(cmd_q);
        run_cmd("after_rst");

`ifdef WB_SERIAL_MASTER_TIMEOUT_EN
        s_noack = 1;
        build(0, 1'b0, 32'h5000_0000, 32'h0, 1'b0);
        model(cmd_q);
        run_cmd("timeout");
        s_noack = 0;
`endif

        for (int r = 0; r < 30; r++) begin
            s_err = ($urandom_range(3) == 0); s_ack_too = $urandom_range(1) == 1;
            s_noack = 0; s_delay = $urandom_range(4); s_rdata = $urandom;
            bp_cycles = $urandom_range(3);
            build($urandom_range(2), $urandom_range(1) == 1, $urandom, $urandom, 1'b1);
            model(cmd_q);
            run_cmd($sformatf("rnd%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
